subcounter_cell: RTL and testbench



---
 rtl/subcounter_cell.sv | 80 ++++++++
 tb/tb_subcounter_cell.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/subcounter_cell.sv
`default_nettype none
// ============================================================================
// Module   : subcounter_cell
// Brief    : One slice of a chained shared counter. Optional sticky wrap flag
//            is enabled by defining SUBCOUNTER_WRAP_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module subcounter_cell #(
  parameter int granularity = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             sub_command_in,
  input  logic [granularity-1:0] load_data_in,
  input  logic                   load_en,
  output logic [granularity-1:0] data_out,
  output logic                   full_out,
  output logic                   wrap_out
);

  localparam logic [1:0] c_CMD_RESET = 2'b00;
  localparam logic [1:0] c_CMD_INCR  = 2'b01;

  logic [granularity-1:0] data_q;
  logic [granularity-1:0] data_d;
  logic                   w_full;

  assign w_full = &data_q;

  always_comb begin
    data_d = data_q;
    if (load_en) begin
      data_d = load_data_in;
    end else if (sub_command_in == c_CMD_RESET) begin
      data_d = '0;
    end else if (sub_command_in == c_CMD_INCR) begin
      data_d = data_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

`ifdef SUBCOUNTER_WRAP_FLAG_EN
  logic wrap_q;
  logic wrap_d;

  // Load and command-reset clear; only an all-ones increment sets.
  always_comb begin
    wrap_d = wrap_q;
    if (load_en || (sub_command_in == c_CMD_RESET)) begin
      wrap_d = 1'b0;
    end else if ((sub_command_in == c_CMD_INCR) && w_full) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_out = wrap_q;
`else
  assign wrap_out = 1'b0;
`endif

  assign data_out = data_q;
  assign full_out = w_full;

endmodule
`default_nettype wire

// File: tb/tb_subcounter_cell.sv
`default_nettype none
// ============================================================================
// Module   : tb_subcounter_cell
// Brief    : Directed self-checking bench for subcounter_cell (granularity 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_subcounter_cell;

  localparam int c_G = 4;

  logic           clk;
  logic           rst_n;
  logic [1:0]     sub_command_in;
  logic [c_G-1:0] load_data_in;
  logic           load_en;
  logic [c_G-1:0] data_out;
  logic           full_out;
  logic           wrap_out;

  int n_checks = 0;
  int n_errors = 0;

  subcounter_cell #(.granularity(c_G)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sub_command_in (sub_command_in),
    .load_data_in   (load_data_in),
    .load_en        (load_en),
    .data_out       (data_out),
    .full_out       (full_out),
    .wrap_out       (wrap_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_wrap(input logic b);
`ifdef SUBCOUNTER_WRAP_FLAG_EN
    return {31'd0, b};
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, capture on the rising edge, return at the next falling edge.
  task automatic step(input logic [1:0] cmd, input logic le, input logic [c_G-1:0] ld);
    sub_command_in = cmd;
    load_en        = le;
    load_data_in   = ld;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    sub_command_in = 2'b10;
    load_en        = 1'b0;
    load_data_in   = '0;
    repeat (2) @(negedge clk);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_full", 32'(full_out), 32'd0);
    check("rst_wrap", 32'(wrap_out), 32'd0);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle from 9
    step(2'b10, 1'b1, 4'd9);
    check("load9", 32'(data_out), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", 32'(data_out), 32'd0);
    check("async_rst_full", 32'(full_out), 32'd0);
    check("async_rst_wrap", 32'(wrap_out), 32'd0);
    @(negedge clk);
    // Reset overrides a load across an edge
    step(2'b01, 1'b1, 4'd5);
    check("rst_over_load", 32'(data_out), 32'd0);
    rst_n = 1'b1;
    step(2'b10, 1'b0, 4'd0);
    check("post_rst_idle", 32'(data_out), 32'd0);

    // Count up to all ones, then wrap
    repeat (15) step(2'b01, 1'b0, 4'd0);
    check("cnt15_data", 32'(data_out), 32'd15);
    check("cnt15_full", 32'(full_out), 32'd1);
    check("cnt15_wrap", 32'(wrap_out), 32'd0);
    step(2'b01, 1'b0, 4'd0);
    check("wrap_data", 32'(data_out), 32'd0);
    check("wrap_full", 32'(full_out), 32'd0);
    check("wrap_flag", 32'(wrap_out), exp_wrap(1'b1));
    step(2'b11, 1'b0, 4'd0);
    check("wrap_sticky_idle", 32'(wrap_out), exp_wrap(1'b1));
    step(2'b01, 1'b0, 4'd0);
    check("wrap_sticky_inc", 32'(wrap_out), exp_wrap(1'b1));
    check("inc_after_wrap", 32'(data_out), 32'd1);

    // Hold with 10 and 11
    step(2'b10, 1'b1, 4'd6);
    check("load6_wrap_clr", 32'(wrap_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 1'b0, 4'd0);
      check("hold_10", 32'(data_out), 32'd6);
    end
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 1'b0, 4'd0);
      check("hold_11", 32'(data_out), 32'd6);
    end

    // Load priority over increment, with wrap set beforehand
    step(2'b10, 1'b1, 4'hF);
    repeat (4) step(2'b01, 1'b0, 4'd0);
    check("pre_prio_data", 32'(data_out), 32'd3);
    check("pre_prio_wrap", 32'(wrap_out), exp_wrap(1'b1));
    step(2'b01, 1'b1, 4'hA);
    check("load_prio_data", 32'(data_out), 32'd10);
    check("load_prio_wrap", 32'(wrap_out), 32'd0);

    // Command reset clears value and wrap
    step(2'b10, 1'b1, 4'hF);
    repeat (13) step(2'b01, 1'b0, 4'd0);
    check("pre_cmd0_data", 32'(data_out), 32'd12);
    check("pre_cmd0_wrap", 32'(wrap_out), exp_wrap(1'b1));
    step(2'b00, 1'b0, 4'd0);
    check("cmd0_data", 32'(data_out), 32'd0);
    check("cmd0_wrap", 32'(wrap_out), 32'd0);
    check("cmd0_full", 32'(full_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
